// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter.
// Accepts one word of DIGITS packed BCD digits and folds one digit per cycle
// into an accumulator (acc*10 + digit), MSD first. The result is held in DONE
// until the consumer accepts it. Out-of-range nibbles (A-F) are still
// accumulated with their raw value; out_err flags the result as garbage.
module bcd2bin_seq #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_bin,
    output logic                  out_err
);

    // 10^n as a constant function, used only for the elaboration-time width check.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam bit WIDTH_OK = (OUT_W >= 64) || ((64'd1 << OUT_W) >= pow10(DIGITS));

    // Reject parameter sets that cannot hold every legal result.
    if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
        $error("bcd2bin_seq: DIGITS must be in 1..9");
    end
    if (!WIDTH_OK) begin : g_bad_width
        $error("bcd2bin_seq: OUT_W too narrow for 10^DIGITS");
    end

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] shreg_q, shreg_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [OUT_W-1:0]    out_bin_q, out_bin_d;
    logic                out_err_q, out_err_d;

    logic [3:0]          digit;
    logic [OUT_W-1:0]    acc_step;
    logic                err_step;

    // Current digit and the accumulator/error values after folding it in.
    always_comb begin
        digit    = shreg_q[4*DIGITS-1 -: 4];
        acc_step = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
        err_step = err_q | (digit > 4'd9);
    end

    // Next-state logic for the IDLE -> CONV -> DONE handshake sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        out_bin_d = out_bin_q;
        out_err_d = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = acc_step;
                shreg_d = shreg_q << 4;
                err_d   = err_step;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    out_bin_d = acc_step;
                    out_err_d = err_step;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            state_q   <= IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_bin_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_bin_q <= out_bin_d;
            out_err_q <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Testbench for bcd2bin_seq: a 4-digit and a 2-digit instance checked against
// a positional-sum reference model, with directed corner cases, backpressure,
// mid-conversion reset and randomized words.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_bcd;
    logic [13:0] out_bin;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [7:0]  b_in_bcd;
    logic [6:0]  b_out_bin;

    int n_vectors = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    bcd2bin_seq #(.DIGITS(4), .OUT_W(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_err(out_err)
    );

    bcd2bin_seq #(.DIGITS(2), .OUT_W(7)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bcd(b_in_bcd),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bin(b_out_bin), .out_err(b_out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value = sum(nibble_k * 10^k) with raw nibbles, modulo 2^out_w.
    function automatic void ref_model(input logic [31:0] w, input int digits, input int out_w,
                                      output int val, output bit err);
        longint sum;
        longint p;
        int     nib;
        sum = 0;
        p   = 1;
        err = 1'b0;
        for (int k = 0; k < digits; k++) begin
            nib = int'((w >> (4 * k)) & 32'hF);
            sum += longint'(nib) * p;
            if (nib > 9) err = 1'b1;
            p *= 10;
        end
        val = int'(sum % (longint'(1) << out_w));
    endfunction

    // Convert one word on the 4-digit instance; called between edges.
    task automatic run4(input logic [15:0] w, input string tag, input bit hold_out);
        int val;
        bit err;
        int cyc;
        ref_model(32'(w), 4, 14, val, err);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_bcd    = w;
        out_ready = !hold_out;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd4);
        check({tag, ".bin"}, 32'(out_bin), 32'(val));
        check({tag, ".err"}, 32'(out_err), 32'(err));
        if (!hold_out) begin
            @(posedge clk); #1;
            check({tag, ".ready_back"}, {30'd0, in_ready, out_valid}, 32'b10);
        end
    endtask

    // Convert one word on the 2-digit instance; called between edges.
    task automatic run2(input logic [7:0] w, input string tag);
        int val;
        bit err;
        int cyc;
        ref_model(32'(w), 2, 7, val, err);
        b_in_valid = 1'b1;
        b_in_bcd   = w;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_bcd   = 8'($urandom);
        cyc = 0;
        while (!b_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd2);
        check({tag, ".bin"}, 32'(b_out_bin), 32'(val));
        check({tag, ".err"}, 32'(b_out_err), 32'(err));
        @(posedge clk); #1;
        check({tag, ".ready_back"}, 32'(b_in_ready), 32'd1);
    endtask

    // Hard stop in case a wait above is ever broken.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words[100];
        int j, tmp;
        bit seen_valid;

        in_valid    = 1'b0;
        in_bcd      = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_bcd    = '0;
        b_out_ready = 1'b1;

        #2;
        check("reset.state4", {28'd0, in_ready, out_valid, out_err, 1'b0}, 32'b1000);
        check("reset.bin4", 32'(out_bin), 32'd0);
        check("reset.state2", {29'd0, b_in_ready, b_out_valid, b_out_err}, 32'b100);

        // Release between edges; the first accept lands on the very next rising edge.
        @(negedge clk);
        rst_n = 1'b1;

        run4(16'h1234, "h1234", 1'b0);
        run4(16'h9999, "h9999", 1'b0);
        run4(16'h0000, "h0000", 1'b0);
        run4(16'h0007, "h0007", 1'b0);
        run4(16'h12A4, "h12A4", 1'b0);
        run4(16'h0001, "h0001", 1'b0);
        for (int i = 0; i < 30; i++) begin
            run4(16'($urandom), $sformatf("rnd%0d", i), 1'b0);
        end

        // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
        run4(16'h0815, "bp", 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_bcd   = 16'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp.hold%0d", i),
                  {16'd0, out_valid, in_ready, out_err, out_bin[12:0]}, {16'd0, 3'b100, 13'd815});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.handshake", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk); #1;
        check("bp.no_accept", {30'd0, in_ready, out_valid}, 32'b10);
        check("bp.bin_kept", 32'(out_bin), 32'd815);

        // Reset during the second CONV cycle.
        check("rst.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bcd   = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst.immediate", {28'd0, in_ready, out_valid, out_err, 1'b0}, 32'b1000);
        check("rst.bin", 32'(out_bin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("rst.no_result", 32'(seen_valid), 32'd0);
        run4(16'h0042, "h0042", 1'b0);

        // Two-digit instance: 99, then every legal word in shuffled order.
        run2(8'h99, "d2.h99");
        for (int i = 0; i < 100; i++) words[i] = i;
        for (int i = 99; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = words[i];
            words[i] = words[j];
            words[j] = tmp;
        end
        for (int i = 0; i < 100; i++) begin
            run2({4'(words[i] / 10), 4'(words[i] % 10)}, $sformatf("d2.w%0d", words[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
